serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first. It is the sequential inverse-operation companion to the team's combinational mux-based full adder. It is built from the same datapath idea: a one-bit full-subtractor cell, a borrow flip-flop, and A/B/D shift registers. A small FSM with a start/done handshake sequences the operation.

Parameters:
N, 8, operand and result width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  N  minuend; captured on accepted start
b  input  N  subtrahend; captured on accepted start
diff  output  N  result register; valid from done until next accepted start
borrow  output  1  final borrow-out (1 when a < b unsigned); valid with diff
busy  output  1  high while an operation is in progress (SHIFT and DONE)
done  output  1  one-cycle pulse, result valid

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): sampled on the rising clk edge only.
- Reset values: state IDLE; diff = 0; borrow = 0; busy = 0; done = 0; bit counter = 0; internal A/B shift regs = 0; borrow FF = 0.
- Reset has priority over everything. Reset mid-operation aborts: no done pulse, and all values return to the reset values above.
- FSM states:
  - IDLE: if start = 1 at an edge, load A <= a, B <= b, clear borrow FF, clear counter, go to SHIFT. Otherwise hold. diff and borrow hold their last values.
  - SHIFT: on each edge:
    - d = A[0] ^ B[0] ^ bf
    - bnext = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bf)
    - diff <= {d, diff[N-1:1]}; A and B shift right with 0 fill; bf <= bnext; counter + 1.
    - The edge that processes bit N-1 moves to DONE and loads borrow <= bnext.
  - DONE: done = 1 and busy = 1 for exactly one cycle. The next edge goes to IDLE.
- Latency: start accepted at edge k; shift edges k+1..k+N; done high between edges k+N and k+N+1. Throughput is one operation per N+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queuing. a and b may change freely after the accept edge.
- diff and borrow are Moore/registered outputs; done and busy decode from state. No combinational path from inputs to outputs.
- During SHIFT, diff contents are intermediate and not a result. The previous result is lost once loading begins.
- Arithmetic is modulo 2^N. diff equals (a - b) mod 2^N. borrow = 1 iff a < b unsigned.
- Counter width is clog2(N). Terminal count is N-1. No wrap beyond N shifts.

Test Plan:
- N=8, reset then idle 3 cycles -> diff=0x00, borrow=0, busy=0, done=0 throughout.
- a=0x5A, b=0x3C, start pulse -> done exactly 9 cycles after the accept edge (N+1), diff=0x1E, borrow=0, busy high 9 cycles.
- a=0x10, b=0x20 -> diff=0xF0, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=0xFF, b=0xFF -> diff=0x00, borrow=0.
- a=0x80, b=0x01 accepted; assert start with a=0x00, b=0x05 during SHIFT and during DONE -> ignored, single done, diff=0x7F, borrow=0. A start held high through the return to IDLE is accepted on the first IDLE edge.
- Accept start, assert rst at shift edge 4 -> no done pulse; next cycle all outputs at reset values. A new op a=0x03, b=0x02 -> diff=0x01, borrow=0.
- Exhaustive for N=4: all 256 (a,b) pairs back-to-back -> each diff and borrow match the reference model, done count = 256.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^N), one bit per clock, LSB first.
// A one-bit full-subtractor cell feeds a borrow flip-flop and the diff shift
// register; a three-state FSM (IDLE -> SHIFT -> DONE) sequences one operation.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           bf_q, bf_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           d_bit;
  logic           b_next;
  logic           last_bit;

  // One-bit full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    d_bit  = a_q[0] ^ b_q[0] ^ bf_q;
    b_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bf_q);
  end

  assign last_bit = (cnt_q == CW'(N - 1));

  // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bf_d     = bf_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        diff_d = {d_bit, diff_q[N-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bf_d   = b_next;
        if (last_bit) begin
          // Counter stops here; it is cleared again on the next accept.
          cnt_d    = '0;
          borrow_d = b_next;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bf_q     <= bf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an N=8 instance for directed and
// random operations and an N=4 instance for an exhaustive back-to-back sweep.
// A transaction-level model predicts busy/done/diff/borrow every cycle.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       borrow8, busy8, done8;
  logic       borrow4, busy4, done4;

  int vectors     = 0;
  int miscompares = 0;
  int done4_cnt   = 0;
  bit model_live  = 1'b0;

  // Model state per instance (index 0: N=8, index 1: N=4). phase counts
  // cycles since the accept edge: 0 idle, 1..W shifting, W+1 done.
  int         m_w[2] = '{8, 4};
  int         m_phase[2];
  logic [7:0] m_res[2], m_pend[2];
  logic       m_bor[2], m_pbor[2];

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .borrow(borrow4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic s,
                            input logic [7:0] ia, input logic [7:0] ib);
    int         w;
    logic [7:0] mask;
    w    = m_w[k];
    mask = 8'((1 << w) - 1);
    if (r) begin
      m_phase[k] = 0;
      m_res[k]   = 8'h00;
      m_bor[k]   = 1'b0;
    end else if (m_phase[k] == 0) begin
      if (s) begin
        m_phase[k] = 1;
        m_pend[k]  = (ia - ib) & mask;
        m_pbor[k]  = (ia < ib);
      end
    end else if (m_phase[k] == w + 1) begin
      m_phase[k] = 0;
    end else begin
      m_phase[k]++;
      if (m_phase[k] == w + 1) begin
        m_res[k] = m_pend[k];
        m_bor[k] = m_pbor[k];
      end
    end
  endtask

  initial begin
    m_phase = '{0, 0};
    m_res   = '{8'h00, 8'h00};
    m_bor   = '{1'b0, 1'b0};
    m_pend  = '{8'h00, 8'h00};
    m_pbor  = '{1'b0, 1'b0};
  end

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    model_step(0, rst, start8, a8, b8);
    model_step(1, rst, start4, {4'h0, a4}, {4'h0, b4});
    model_live = 1'b1;
  end

  // Compare process: outputs sampled on the falling edge, every cycle.
  always @(negedge clk) begin
    if (model_live) begin
      check("busy8", busy8, m_phase[0] != 0);
      check("done8", done8, m_phase[0] == 9);
      if (m_phase[0] == 0 || m_phase[0] == 9) begin
        check("diff8", diff8, m_res[0]);
        check("borrow8", borrow8, m_bor[0]);
      end
      check("busy4", busy4, m_phase[1] != 0);
      check("done4", done4, m_phase[1] == 5);
      if (m_phase[1] == 0 || m_phase[1] == 5) begin
        check("diff4", diff4, m_res[1][3:0]);
        check("borrow4", borrow4, m_bor[1]);
      end
      if (done4 === 1'b1) done4_cnt++;
    end
  end

  // Waits (bounded) for done8; cyc is the cycle index after the accept edge.
  task automatic wait_done8(input int first_cyc, output int cyc, output int bcnt);
    cyc  = first_cyc;
    bcnt = first_cyc - 1;
    while (done8 !== 1'b1 && cyc < 20) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (done8 === 1'b1 && busy8 === 1'b1) bcnt++;
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic [7:0] ed, input logic eb, input string tag);
    int cyc, bcnt;
    @(negedge clk);
    start8 = 1'b1; a8 = ia; b8 = ib;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(1, cyc, bcnt);
    check({tag, "_done_cycle"}, cyc, 9);
    check({tag, "_busy_cycles"}, bcnt, 9);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_borrow"}, borrow8, eb);
  endtask

  initial begin
    int cyc, bcnt, dcount, t;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state held through three idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_diff", diff8, 8'h00);
      check("rst_borrow", borrow8, 1'b0);
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
    end

    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "op_5a_3c");
    op8(8'h10, 8'h20, 8'hF0, 1'b1, "op_10_20");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, "op_ff_ff");

    // Start during SHIFT and DONE is ignored; a start held into IDLE is taken.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h05;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(4, cyc, bcnt);
    check("ign_done_cycle", cyc, 9);
    check("ign_diff", diff8, 8'h7F);
    check("ign_borrow", borrow8, 1'b0);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h05;
    @(negedge clk);
    check("ign_start_in_done", busy8, 1'b0);
    @(negedge clk);
    check("held_start_accepted", busy8, 1'b1);
    start8 = 1'b0;
    wait_done8(1, cyc, bcnt);
    check("held_done_cycle", cyc, 9);
    check("held_diff", diff8, 8'hFB);
    check("held_borrow", borrow8, 1'b1);

    // Reset sampled on shift edge 4 aborts the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_diff", diff8, 8'h00);
    check("abort_borrow", borrow8, 1'b0);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    op8(8'h03, 8'h02, 8'h01, 1'b0, "op_03_02");

    // Random operations with random start noise while busy.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      t = 0;
      while (done8 !== 1'b1 && t < 20) begin
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom);
        @(negedge clk);
        t++;
      end
      check("rand_done_seen", done8, 1'b1);
      start8 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Exhaustive N=4 sweep with start held high, one pair per operation.
    for (int i = 0; i < 256; i++) begin
      t = 0;
      while (busy4 !== 1'b0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check("n4_idle_timeout", t, 0);
      a4 = 4'(i >> 4); b4 = 4'(i);
      start4 = 1'b1;
      @(negedge clk);
    end
    t = 0;
    while (busy4 !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    start4 = 1'b0;
    @(negedge clk);
    check("n4_done_count", done4_cnt, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
